scr1_vec_lsu: RTL

Vector load/store sequencer sitting directly upstream of the TCM data port. It accepts one strided block command (base, count, stride, load/store), issues one full-vector `dmem` request per beat, and streams `LANE`×32-bit vectors between the TCM and a ready/valid data channel. It tracks outstanding responses, buffers load data in a 2-entry FIFO, and reports completion and errors per command.

---
 rtl/scr1_vec_pkg.sv | 42 ++++
 rtl/scr1_vec_fifo2.sv | 65 ++++++
 rtl/scr1_vec_lsu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scr1_vec_pkg.sv
// Shared definitions for the vector load/store sequencer.
// Contents: lane count and vector type, the TCM data-port enums (including
// the full-vector width code), the sequencer FSM state enum and a small
// alignment helper.
package scr1_vec_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int LANE             = 4;
    localparam int VEC_W            = LANE * 32;

    typedef logic [VEC_W-1:0] type_vector;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_VEC   = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        VLSU_IDLE  = 2'b00,
        VLSU_RUN   = 2'b01,
        VLSU_DRAIN = 2'b10
    } type_vlsu_state_e;

    // True when a byte address/offset is not a multiple of 4.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/scr1_vec_fifo2.sv
// Two-entry FIFO of type_vector used to buffer load data.
// Ports: clk, rst (async, active-high), push/push_data (write),
//        pop (read; ignored when empty), head (oldest entry, 0 when empty),
//        count (occupancy 0..2).
module scr1_vec_fifo2
    import scr1_vec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  type_vector push_data,
    input  logic       pop,
    output type_vector head,
    output logic [1:0] count
);

    type_vector mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        pop_ok   = pop && (count_q != 2'd0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = ~wr_ptr_q;
        if (pop_ok) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only observable once count marks it valid.
    // When full, a simultaneous push overwrites the slot being popped, which is safe.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    // The upstream issue gate guarantees a push never lands on a full FIFO without a pop.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop_ok && count_q == 2'd2));
    end

endmodule

// File: rtl/scr1_vec_lsu.sv
// Strided vector load/store sequencer in front of the TCM data port.
// Accepts one command (base, count, stride, load/store), issues one full-vector
// dmem request per beat and streams vectors between the TCM and rd_*/wr_*.
// Ports: cmd_* command handshake; wr_* store data in; rd_* load data out;
//        done/done_err completion pulse; dmem_* TCM request/response port.
module scr1_vec_lsu
    import scr1_vec_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int STRIDE_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_store,
    input  logic [SCR1_DMEM_AWIDTH-1:0] cmd_base,
    input  logic [CNT_W-1:0]            cmd_count,
    input  logic [STRIDE_W-1:0]         cmd_stride,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  type_vector                  wr_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output type_vector                  rd_data,
    output logic                        done,
    output logic                        done_err,
    output logic                        dmem_req,
    input  logic                        dmem_req_ack,
    output type_scr1_mem_cmd_e          dmem_cmd,
    output type_scr1_mem_width_e        dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    output type_vector                  dmem_wdata,
    input  type_vector                  dmem_rdata,
    input  type_scr1_mem_resp_e         dmem_resp
);

    localparam int AW = SCR1_DMEM_AWIDTH;

    type_vlsu_state_e      state_q, state_d;
    logic                  store_q, store_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      k_q, k_d;
    logic [STRIDE_W-1:0]   stride_q, stride_d;
    logic                  err_q, err_d;
    logic [1:0]            outst_q, outst_d;

    logic       run_load, run_store, beat, retire, drain_done, load_gate;
    logic       fifo_push, fifo_pop;
    logic [1:0] fifo_cnt;
    logic [2:0] inflight;
    type_vector fifo_push_data;

    scr1_vec_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (rd_data),
        .count     (fifo_cnt)
    );

    // Datapath outputs decode the registered state, so reset clears them asynchronously.
    always_comb begin
        run_load   = (state_q == VLSU_RUN) && !store_q;
        run_store  = (state_q == VLSU_RUN) &&  store_q;
        cmd_ready  = (state_q == VLSU_IDLE) && !rst;
        rd_valid   = (fifo_cnt != 2'd0);
        fifo_pop   = rd_valid && rd_ready;
        // Slots already claimed once this cycle's pop is taken into account;
        // keeps FIFO + in-flight beats <= 2 while allowing 1 vector/cycle.
        inflight   = 3'(fifo_cnt) + 3'(outst_q) - 3'(fifo_pop);
        load_gate  = inflight < 3'd2;
        dmem_req   = run_load ? load_gate : (run_store ? wr_valid : 1'b0);
        dmem_cmd   = run_store ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_VEC;
        dmem_addr  = (state_q == VLSU_RUN) ? addr_q : '0;
        dmem_wdata = run_store ? wr_data : '0;
        wr_ready   = run_store && dmem_req_ack;
        beat       = dmem_req && dmem_req_ack;
        // Ignore stray responses when nothing is outstanding (e.g. just after reset).
        retire     = (dmem_resp != SCR1_MEM_RESP_NOTRDY) && (outst_q != 2'd0);
        fifo_push  = retire && !store_q;
        // Error beats push zero so the load still delivers exactly count vectors.
        fifo_push_data = (dmem_resp == SCR1_MEM_RESP_RDY_OK) ? dmem_rdata : '0;
        drain_done = (state_q == VLSU_DRAIN) && (outst_q == 2'd0) && (store_q || !rd_valid);
        done       = drain_done;
        done_err   = drain_done && err_q;
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        addr_d   = addr_q;
        count_d  = count_q;
        k_d      = k_q;
        stride_d = stride_q;
        err_d    = err_q;
        outst_d  = outst_q;

        case ({beat, retire})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase
        if (retire && dmem_resp == SCR1_MEM_RESP_RDY_ER) err_d = 1'b1;

        case (state_q)
            VLSU_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    store_d  = cmd_store;
                    addr_d   = cmd_base;
                    count_d  = cmd_count;
                    stride_d = cmd_stride;
                    k_d      = '0;
                    outst_d  = 2'd0;
                    err_d    = 1'b0;
                    if (cmd_count == '0) begin
                        state_d = VLSU_DRAIN;
                    end else if (is_misaligned(cmd_base[1:0]) || is_misaligned(cmd_stride[1:0])) begin
                        err_d   = 1'b1;
                        state_d = VLSU_DRAIN;
                    end else begin
                        state_d = VLSU_RUN;
                    end
                end
            end
            VLSU_RUN: begin
                if (beat) begin
                    k_d    = k_q + CNT_W'(1);
                    // Running address; wraps silently modulo 2^AW.
                    addr_d = addr_q + AW'(stride_q);
                    if (k_q == count_q - CNT_W'(1)) state_d = VLSU_DRAIN;
                end
            end
            VLSU_DRAIN: begin
                if (drain_done) state_d = VLSU_IDLE;
            end
            default: state_d = VLSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= VLSU_IDLE;
            store_q  <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            k_q      <= '0;
            stride_q <= '0;
            err_q    <= 1'b0;
            outst_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            k_q      <= k_d;
            stride_q <= stride_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
        end
    end

endmodule
